// File: rtl/decoder_scan_nto2n_pkg.sv
// rtl/decoder_scan_nto2n_pkg.sv - shared state, mode and counter definitions for the scanning decoder
package decoder_scan_nto2n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int CNT_W = 16;

endpackage

// File: rtl/onehot_decode_n.sv
// rtl/onehot_decode_n.sv - combinational n-to-2^n one-hot decoder with enable
module onehot_decode_n #(
    parameter int SEL_W = 2
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   o
);

    always_comb begin
        o = '0;
        if (en) begin
            o[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan_nto2n.sv
// rtl/decoder_scan_nto2n.sv - registered one-hot decoder with direct select and auto-scan modes
module decoder_scan_nto2n
    import decoder_scan_nto2n_pkg::*;
#(
    parameter int SEL_W  = 2,
    parameter int PERIOD = 4,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    input  logic             mode,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel,
    output logic             sel_ready,
    output logic [OUT_W-1:0] o,
    output logic [SEL_W-1:0] cur_sel,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [OUT_W-1:0]   o_nxt;
    logic               transfer;
    logic               scanning;
    logic               advance;

    always_comb begin
        state_nxt = ST_IDLE;
        if (En) begin
            state_nxt = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        end
    end

    assign sel_ready = En & (mode == MODE_DIRECT);
    assign transfer  = sel_valid & sel_ready;

    // The cycle of entry into SCAN only shows the held index; dwell counting starts after it.
    assign scanning  = (state == ST_SCAN) && (state_nxt == ST_SCAN);
    assign advance   = scanning && (cnt == LAST);

    always_comb begin
        sel_nxt = cur_sel;
        cnt_nxt = '0;
        if (transfer) begin
            sel_nxt = sel;
        end else if (advance) begin
            sel_nxt = cur_sel + 1'b1;
        end
        if (scanning && !advance) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    onehot_decode_n #(
        .SEL_W (SEL_W)
    ) u_dec (
        .en  (state_nxt != ST_IDLE),
        .sel (sel_nxt),
        .o   (o_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cur_sel <= '0;
            o       <= '0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cur_sel <= sel_nxt;
            o       <= o_nxt;
            wrap    <= advance && (&cur_sel);
        end
    end

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// tb/tb_decoder_scan_nto2n.sv - directed self-checking bench for decoder_scan_nto2n
module tb_decoder_scan_nto2n;

    logic       clk;
    logic       rst;

    logic       En;
    logic       mode;
    logic       sel_valid;
    logic [1:0] sel;
    logic       sel_ready;
    logic [3:0] o;
    logic [1:0] cur_sel;
    logic       wrap;

    logic       en2;
    logic       mode2;
    logic       sel_valid2;
    logic [2:0] sel2;
    logic       sel_ready2;
    logic [7:0] o2;
    logic [2:0] cur_sel2;
    logic       wrap2;

    int checks;
    int errors;

    decoder_scan_nto2n #(.SEL_W(2), .PERIOD(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .En        (En),
        .mode      (mode),
        .sel_valid (sel_valid),
        .sel       (sel),
        .sel_ready (sel_ready),
        .o         (o),
        .cur_sel   (cur_sel),
        .wrap      (wrap)
    );

    decoder_scan_nto2n #(.SEL_W(3), .PERIOD(1)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .En        (en2),
        .mode      (mode2),
        .sel_valid (sel_valid2),
        .sel       (sel2),
        .sel_ready (sel_ready2),
        .o         (o2),
        .cur_sel   (cur_sel2),
        .wrap      (wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (o !== 4'b0000) begin errors++; $display("FAIL reset_o got=%b exp=0000", o); end
        checks++;
        if (cur_sel !== 2'd0) begin errors++; $display("FAIL reset_cur_sel got=%0d exp=0", cur_sel); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        En = 1'b1;
        #1;
        checks++;
        if (sel_ready !== 1'b1) begin errors++; $display("FAIL reset_sel_ready got=%b exp=1", sel_ready); end
        En = 1'b0;
        #1;
        checks++;
        if (o2 !== 8'h00) begin errors++; $display("FAIL reset_o8 got=%b exp=00000000", o2); end
    endtask

    task automatic test_direct();
        En = 1'b1; mode = 1'b0; sel_valid = 1'b1; sel = 2'd2;
        #1;
        checks++;
        if (sel_ready !== 1'b1) begin errors++; $display("FAIL direct_ready got=%b exp=1", sel_ready); end
        step();
        sel_valid = 1'b0;
        checks++;
        if (o !== 4'b0100) begin errors++; $display("FAIL direct_o got=%b exp=0100", o); end
        checks++;
        if (cur_sel !== 2'd2) begin errors++; $display("FAIL direct_cur_sel got=%0d exp=2", cur_sel); end
    endtask

    task automatic test_enable();
        sel_valid = 1'b1; sel = 2'd3;
        step();
        checks++;
        if (o !== 4'b1000) begin errors++; $display("FAIL en_pre_o got=%b exp=1000", o); end
        En = 1'b0;
        #1;
        checks++;
        if (sel_ready !== 1'b0) begin errors++; $display("FAIL en_ready got=%b exp=0", sel_ready); end
        step();
        checks++;
        if (o !== 4'b0000) begin errors++; $display("FAIL en_off_o1 got=%b exp=0000", o); end
        sel = 2'd1;
        step();
        checks++;
        if (o !== 4'b0000) begin errors++; $display("FAIL en_off_o2 got=%b exp=0000", o); end
        checks++;
        if (cur_sel !== 2'd3) begin errors++; $display("FAIL en_off_cur_sel got=%0d exp=3", cur_sel); end
        sel_valid = 1'b0; sel = 2'd3;
        En = 1'b1;
        step();
        checks++;
        if (o !== 4'b1000) begin errors++; $display("FAIL en_back_o got=%b exp=1000", o); end
        En = 1'b0; mode = 1'b1;
        step();
        checks++;
        if (o !== 4'b0000) begin errors++; $display("FAIL en_priority_o got=%b exp=0000", o); end
        En = 1'b1; mode = 1'b0;
        step();
        checks++;
        if (o !== 4'b1000) begin errors++; $display("FAIL en_priority_back got=%b exp=1000", o); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_o;
        logic       exp_w;
        sel_valid = 1'b1; sel = 2'd0;
        step();
        checks++;
        if (o !== 4'b0001) begin errors++; $display("FAIL scan_start_o got=%b exp=0001", o); end
        mode = 1'b1; sel = 2'd3;
        for (int i = 0; i < 14; i++) begin
            step();
            exp_o = 4'b0001 << ((i / 3) % 4);
            exp_w = (i == 12);
            checks++;
            if (o !== exp_o) begin errors++; $display("FAIL scan_o step=%0d got=%b exp=%b", i, o, exp_o); end
            checks++;
            if (wrap !== exp_w) begin errors++; $display("FAIL scan_wrap step=%0d got=%b exp=%b", i, wrap, exp_w); end
        end
    endtask

    task automatic test_handoff();
        step();
        step();
        checks++;
        if (o !== 4'b0010) begin errors++; $display("FAIL hand_at1 got=%b exp=0010", o); end
        mode = 1'b0; sel_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (o !== 4'b0010) begin errors++; $display("FAIL hand_hold step=%0d got=%b exp=0010", i, o); end
        end
        sel_valid = 1'b1; sel = 2'd3;
        step();
        sel_valid = 1'b0;
        checks++;
        if (o !== 4'b1000) begin errors++; $display("FAIL hand_xfer got=%b exp=1000", o); end
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o !== 4'b1000 || wrap !== 1'b0) begin
                errors++; $display("FAIL hand_resume step=%0d got=%b/%b exp=1000/0", i, o, wrap);
            end
        end
        step();
        checks++;
        if (o !== 4'b0001 || wrap !== 1'b1) begin
            errors++; $display("FAIL hand_wrap got=%b/%b exp=0001/1", o, wrap);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 20 && cur_sel !== 2'd2; k++) begin
            step();
        end
        checks++;
        if (cur_sel !== 2'd2 || o !== 4'b0100) begin
            errors++; $display("FAIL ares_reach got=%0d/%b exp=2/0100", cur_sel, o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (o !== 4'b0000) begin errors++; $display("FAIL ares_o got=%b exp=0000", o); end
        checks++;
        if (cur_sel !== 2'd0) begin errors++; $display("FAIL ares_cur_sel got=%0d exp=0", cur_sel); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL ares_wrap got=%b exp=0", wrap); end
        step();
        rst = 1'b0; En = 1'b1; mode = 1'b0; sel_valid = 1'b0;
        step();
        checks++;
        if (o !== 4'b0001) begin errors++; $display("FAIL ares_first_o got=%b exp=0001", o); end
    endtask

    task automatic test_period1();
        logic [7:0] exp_o;
        logic       exp_w;
        en2 = 1'b1; mode2 = 1'b1; sel_valid2 = 1'b1; sel2 = 3'd5;
        for (int i = 0; i < 17; i++) begin
            step();
            exp_o = 8'h01 << (i % 8);
            exp_w = (i == 8) || (i == 16);
            checks++;
            if (o2 !== exp_o) begin errors++; $display("FAIL p1_o step=%0d got=%b exp=%b", i, o2, exp_o); end
            checks++;
            if (wrap2 !== exp_w) begin errors++; $display("FAIL p1_wrap step=%0d got=%b exp=%b", i, wrap2, exp_w); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        En = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = 2'd0;
        en2 = 1'b0; mode2 = 1'b0; sel_valid2 = 1'b0; sel2 = 3'd0;
        step();
        step();
        test_reset();
        rst = 1'b0;
        test_direct();
        test_enable();
        test_scan();
        test_handoff();
        test_async_reset();
        test_period1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
